// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI4 write master among NUM_REQ VDM requesters.
// One transaction in flight (AW -> W -> B); WLAST is generated locally and requester WLAST/BID are checked.
//
// state  | meaning
// S_IDLE | no owner; round-robin search from r_rr_ptr, accept winner's address
// S_AW   | latched address presented on O_AWVALID until I_AWREADY
// S_W    | data beats passed through from owner; r_beat_cnt counts down to last beat
// S_B    | response routed back to owner; rr pointer advances on handshake
module axi_wr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DW      = 256
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NUM_REQ-1:0]        I_REQ_AWVALID,
  input  logic [NUM_REQ*64-1:0]     I_REQ_AWADDR,
  input  logic [NUM_REQ*8-1:0]      I_REQ_AWLEN,
  output logic [NUM_REQ-1:0]        O_REQ_AWREADY,
  input  logic [NUM_REQ*DW-1:0]     I_REQ_WDATA,
  input  logic [NUM_REQ*DW/8-1:0]   I_REQ_WSTRB,
  input  logic [NUM_REQ-1:0]        I_REQ_WLAST,
  input  logic [NUM_REQ-1:0]        I_REQ_WVALID,
  output logic [NUM_REQ-1:0]        O_REQ_WREADY,
  output logic [NUM_REQ-1:0]        O_REQ_BVALID,
  output logic [1:0]                O_REQ_BRESP,
  input  logic [NUM_REQ-1:0]        I_REQ_BREADY,
  output logic [6:0]                O_AWID,
  output logic [63:0]               O_AWADDR,
  output logic [7:0]                O_AWLEN,
  output logic [2:0]                O_AWSIZE,
  output logic [1:0]                O_AWBURST,
  output logic                      O_AWVALID,
  input  logic                      I_AWREADY,
  output logic [DW-1:0]             O_WDATA,
  output logic [DW/8-1:0]           O_WSTRB,
  output logic                      O_WLAST,
  output logic                      O_WVALID,
  input  logic                      I_WREADY,
  input  logic [6:0]                I_BID,
  input  logic [1:0]                I_BRESP,
  input  logic                      I_BVALID,
  output logic                      O_BREADY,
  output logic                      O_ERR,
  output logic [NUM_REQ-1:0]        O_GRANT
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = DW / 8;

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_gnt_idx;
  logic [IW-1:0] r_rr_ptr;
  logic [63:0]   r_aw_addr;
  logic [7:0]    r_aw_len;
  logic [7:0]    r_beat_cnt;
  logic          r_err;

  logic [IW-1:0] w_win;
  logic [IW-1:0] w_rr_nxt;
  logic [IW:0]   w_sum;
  logic          w_found;
  logic          w_last;
  logic          w_w_hs;
  logic          w_b_hs;

  // Iterate from lowest priority to highest so the last hit is the winner.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_sum = {1'b0, r_rr_ptr} + (IW+1)'(i);
      if (w_sum >= (IW+1)'(NUM_REQ)) w_sum = w_sum - (IW+1)'(NUM_REQ);
      if (I_REQ_AWVALID[w_sum[IW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[IW-1:0];
      end
    end
  end

  assign w_rr_nxt = (r_gnt_idx == IW'(NUM_REQ - 1)) ? '0 : r_gnt_idx + IW'(1);
  assign w_last   = (r_beat_cnt == 8'd0);
  assign w_w_hs   = (r_state == S_W) && I_REQ_WVALID[r_gnt_idx] && I_WREADY;
  assign w_b_hs   = (r_state == S_B) && I_BVALID && I_REQ_BREADY[r_gnt_idx];

  always_comb begin
    w_state_nxt   = r_state;
    O_REQ_AWREADY = '0;
    O_REQ_WREADY  = '0;
    O_REQ_BVALID  = '0;
    O_REQ_BRESP   = 2'b00;
    O_AWVALID     = 1'b0;
    O_WDATA       = '0;
    O_WSTRB       = '0;
    O_WLAST       = 1'b0;
    O_WVALID      = 1'b0;
    O_BREADY      = 1'b0;
    O_GRANT       = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          O_REQ_AWREADY[w_win] = 1'b1;
          w_state_nxt          = S_AW;
        end
      end
      S_AW: begin
        O_AWVALID          = 1'b1;
        O_GRANT[r_gnt_idx] = 1'b1;
        if (I_AWREADY) w_state_nxt = S_W;
      end
      S_W: begin
        O_GRANT[r_gnt_idx]      = 1'b1;
        O_WVALID                = I_REQ_WVALID[r_gnt_idx];
        O_REQ_WREADY[r_gnt_idx] = I_WREADY;
        O_WDATA                 = I_REQ_WDATA[DW*int'(r_gnt_idx) +: DW];
        O_WSTRB                 = I_REQ_WSTRB[SW*int'(r_gnt_idx) +: SW];
        O_WLAST                 = w_last;
        if (w_w_hs && w_last) w_state_nxt = S_B;
      end
      S_B: begin
        O_GRANT[r_gnt_idx]      = 1'b1;
        O_BREADY                = I_REQ_BREADY[r_gnt_idx];
        O_REQ_BVALID[r_gnt_idx] = I_BVALID;
        O_REQ_BRESP             = I_BRESP;
        if (w_b_hs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_gnt_idx  <= '0;
      r_rr_ptr   <= '0;
      r_aw_addr  <= '0;
      r_aw_len   <= '0;
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt_idx <= w_win;
            r_aw_addr <= I_REQ_AWADDR[64*int'(w_win) +: 64];
            r_aw_len  <= I_REQ_AWLEN[8*int'(w_win) +: 8];
          end
        end
        S_AW: begin
          if (I_AWREADY) r_beat_cnt <= r_aw_len;
        end
        S_W: begin
          if (w_w_hs) begin
            // Counter holds at zero on the last beat so len=255 never wraps.
            if (!w_last) r_beat_cnt <= r_beat_cnt - 8'd1;
            if (I_REQ_WLAST[r_gnt_idx] != w_last) r_err <= 1'b1;
          end
        end
        S_B: begin
          if (w_b_hs) begin
            if (I_BID != 7'(r_gnt_idx)) r_err <= 1'b1;
            r_rr_ptr <= w_rr_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign O_AWID    = 7'(r_gnt_idx);
  assign O_AWADDR  = r_aw_addr;
  assign O_AWLEN   = r_aw_len;
  assign O_AWSIZE  = 3'd5;
  assign O_AWBURST = 2'b01;
  assign O_ERR     = r_err;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter (NUM_REQ=2, DW=256): single burst, contention,
// backpressure, WLAST/BID error detection and mid-burst reset.
module tb_axi_wr_arbiter;

  localparam int NR = 2;
  localparam int DW = 256;

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic [NR-1:0]     req_awvalid;
  logic [NR*64-1:0]  req_awaddr;
  logic [NR*8-1:0]   req_awlen;
  logic [NR-1:0]     o_req_awready;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR*DW/8-1:0] req_wstrb;
  logic [NR-1:0]     req_wlast;
  logic [NR-1:0]     req_wvalid;
  logic [NR-1:0]     o_req_wready;
  logic [NR-1:0]     o_req_bvalid;
  logic [1:0]        o_req_bresp;
  logic [NR-1:0]     req_bready;
  logic [6:0]        o_awid;
  logic [63:0]       o_awaddr;
  logic [7:0]        o_awlen;
  logic [2:0]        o_awsize;
  logic [1:0]        o_awburst;
  logic              o_awvalid;
  logic              awready;
  logic [DW-1:0]     o_wdata;
  logic [DW/8-1:0]   o_wstrb;
  logic              o_wlast;
  logic              o_wvalid;
  logic              wready;
  logic [6:0]        bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              o_bready;
  logic              o_err;
  logic [NR-1:0]     o_grant;

  int   n_assert = 0;
  int   n_fail   = 0;
  logic exp_err  = 1'b0;

  axi_wr_arbiter #(.NUM_REQ(NR), .DW(DW)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .I_REQ_AWVALID(req_awvalid), .I_REQ_AWADDR(req_awaddr), .I_REQ_AWLEN(req_awlen),
    .O_REQ_AWREADY(o_req_awready),
    .I_REQ_WDATA(req_wdata), .I_REQ_WSTRB(req_wstrb), .I_REQ_WLAST(req_wlast),
    .I_REQ_WVALID(req_wvalid), .O_REQ_WREADY(o_req_wready),
    .O_REQ_BVALID(o_req_bvalid), .O_REQ_BRESP(o_req_bresp), .I_REQ_BREADY(req_bready),
    .O_AWID(o_awid), .O_AWADDR(o_awaddr), .O_AWLEN(o_awlen), .O_AWSIZE(o_awsize),
    .O_AWBURST(o_awburst), .O_AWVALID(o_awvalid), .I_AWREADY(awready),
    .O_WDATA(o_wdata), .O_WSTRB(o_wstrb), .O_WLAST(o_wlast), .O_WVALID(o_wvalid),
    .I_WREADY(wready),
    .I_BID(bid), .I_BRESP(bresp), .I_BVALID(bvalid), .O_BREADY(o_bready),
    .O_ERR(o_err), .O_GRANT(o_grant)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [255:0] beat_data(input int req, input int b, input logic [127:0] hdr);
    if (b == 0) return {128'(req + 1), hdr};
    return {8{32'(req * 65536 + b)}};
  endfunction

  task automatic do_reset();
    req_awvalid = '0;
    req_wvalid  = '0;
    req_wlast   = '0;
    bvalid      = 1'b0;
    i_reset     = 1'b1;
    step();
    i_reset     = 1'b0;
    exp_err     = 1'b0;
  endtask

  // One complete transaction for requester req, from AW accept to B handshake.
  task automatic burst(input int req, input int len, input logic [63:0] addr,
                       input logic [127:0] hdr, input int aw_stall, input bit wr_toggle,
                       input int bad_beat, input logic [6:0] rsp_id, input logic [1:0] rsp);
    int k;
    int b;
    int cyc;
    logic [255:0] one_hot;
    one_hot = 256'(1) << req;
    req_awaddr[req*64 +: 64] = addr;
    req_awlen[req*8 +: 8]    = 8'(len);
    req_awvalid[req]         = 1'b1;
    req_bready[req]          = 1'b1;
    awready                  = 1'b1;
    #1;
    k = 0;
    while (o_req_awready == '0 && k < 20) begin
      step();
      k++;
    end
    chk("aw_accept", 256'(o_req_awready), one_hot);
    step();
    req_awvalid[req] = 1'b0;
    awready          = (aw_stall == 0);
    req_wstrb[req*32 +: 32] = '1;
    req_wvalid[req]  = 1'b1;
    #1;
    chk("awvalid", 256'(o_awvalid), 256'(1));
    chk("awid", 256'(o_awid), 256'(req));
    chk("awaddr", 256'(o_awaddr), 256'(addr));
    chk("awlen", 256'(o_awlen), 256'(len));
    chk("grant_aw", 256'(o_grant), one_hot);
    for (int s = 0; s < aw_stall; s++) begin
      step();
      if (s == aw_stall - 1) awready = 1'b1;
      chk("aw_hold_valid", 256'(o_awvalid), 256'(1));
      chk("aw_hold_addr", 256'(o_awaddr), 256'(addr));
    end
    step();
    b   = 0;
    cyc = 0;
    while (b <= len && cyc < 600) begin
      wready = wr_toggle ? (cyc % 2 == 0) : 1'b1;
      req_wdata[req*DW +: DW] = beat_data(req, b, hdr);
      req_wlast[req] = (b == len) || (b == bad_beat);
      #1;
      chk("w_in_sw", 256'(o_wvalid), 256'(1));
      chk("w_err", 256'(o_err), 256'(exp_err));
      chk("w_wready", 256'(o_req_wready), wready ? one_hot : 256'(0));
      if (wready) begin
        chk("wlast", 256'(o_wlast), 256'(b == len));
        chk("wdata", o_wdata, beat_data(req, b, hdr));
        chk("wstrb", 256'(o_wstrb), 256'(32'hFFFF_FFFF));
      end
      step();
      if (wready) begin
        if (req_wlast[req] != (b == len)) exp_err = 1'b1;
        b++;
      end
      cyc++;
    end
    chk("w_beats", 256'(b), 256'(len + 1));
    req_wvalid[req] = 1'b0;
    req_wlast[req]  = 1'b0;
    bid    = rsp_id;
    bresp  = rsp;
    bvalid = 1'b1;
    #1;
    chk("sb_wvalid", 256'(o_wvalid), 256'(0));
    chk("bvalid", 256'(o_req_bvalid), one_hot);
    chk("bresp", 256'(o_req_bresp), 256'(rsp));
    chk("bready", 256'(o_bready), 256'(1));
    step();
    bvalid = 1'b0;
    if (rsp_id != 7'(req)) exp_err = 1'b1;
    #1;
    chk("idle_grant", 256'(o_grant), 256'(0));
    chk("b_err", 256'(o_err), 256'(exp_err));
  endtask

  initial begin
    i_reset     = 1'b1;
    req_awvalid = '0;
    req_awaddr  = '0;
    req_awlen   = '0;
    req_wdata   = '0;
    req_wstrb   = '0;
    req_wlast   = '0;
    req_wvalid  = '0;
    req_bready  = '0;
    awready     = 1'b0;
    wready      = 1'b0;
    bid         = '0;
    bresp       = '0;
    bvalid      = 1'b0;
    step();
    step();
    chk("rst_awvalid", 256'(o_awvalid), 256'(0));
    chk("rst_awsize", 256'(o_awsize), 256'(5));
    chk("rst_awburst", 256'(o_awburst), 256'(1));
    chk("rst_grant", 256'(o_grant), 256'(0));
    chk("rst_err", 256'(o_err), 256'(0));
    chk("rst_awaddr", 256'(o_awaddr), 256'(0));
    chk("rst_awready", 256'(o_req_awready), 256'(0));
    chk("rst_bready", 256'(o_bready), 256'(0));
    i_reset = 1'b0;

    // Single requester, len=0.
    burst(0, 0, 64'h0, 128'hDEADBEEF_CAFEBABE_12345678_ABCDEF01, 0, 1'b0, -1, 7'd0, 2'b00);

    // Contention: req1 already waiting when req0 is granted.
    do_reset();
    req_awaddr[64 +: 64] = 64'h2000;
    req_awlen[8 +: 8]    = 8'd3;
    req_awvalid[1]       = 1'b1;
    burst(0, 3, 64'h1000, 128'h0A0A_0001, 0, 1'b0, -1, 7'd0, 2'b00);
    burst(1, 3, 64'h2000, 128'h0B0B_0002, 0, 1'b0, -1, 7'd1, 2'b10);
    burst(0, 3, 64'h1040, 128'h0A0A_0003, 0, 1'b0, -1, 7'd0, 2'b00);

    // Backpressure on AW and W.
    burst(0, 3, 64'h10, 128'h0C0C_0004, 3, 1'b1, -1, 7'd0, 2'b00);

    // Requester WLAST early on beat 1.
    burst(1, 3, 64'h3000, 128'h0D0D_0005, 0, 1'b0, 1, 7'd1, 2'b00);
    chk("err_sticky", 256'(o_err), 256'(1));

    // Wrong BID.
    do_reset();
    burst(0, 0, 64'h4000, 128'h0E0E_0006, 0, 1'b0, -1, 7'd5, 2'b00);

    // Reset while req1 is in the data phase.
    req_awaddr[64 +: 64] = 64'h5000;
    req_awlen[8 +: 8]    = 8'd3;
    req_awvalid[1]       = 1'b1;
    req_bready[1]        = 1'b1;
    #1;
    chk("pre_rst_accept", 256'(o_req_awready), 256'(2'b10));
    step();
    req_awvalid[1] = 1'b0;
    awready        = 1'b1;
    step();
    req_wvalid[1] = 1'b1;
    wready        = 1'b0;
    #1;
    chk("pre_rst_grant", 256'(o_grant), 256'(2'b10));
    do_reset();
    #1;
    chk("mid_rst_grant", 256'(o_grant), 256'(0));
    chk("mid_rst_err", 256'(o_err), 256'(0));
    chk("mid_rst_awvalid", 256'(o_awvalid), 256'(0));
    chk("mid_rst_wvalid", 256'(o_wvalid), 256'(0));
    chk("mid_rst_wdata", o_wdata, 256'(0));
    chk("mid_rst_awid", 256'(o_awid), 256'(0));
    chk("mid_rst_awaddr", 256'(o_awaddr), 256'(0));
    chk("mid_rst_awlen", 256'(o_awlen), 256'(0));
    chk("mid_rst_wready", 256'(o_req_wready), 256'(0));
    chk("mid_rst_awsize", 256'(o_awsize), 256'(5));
    req_awvalid = 2'b11;
    #1;
    chk("post_rst_accept", 256'(o_req_awready), 256'(2'b01));
    burst(0, 1, 64'h6000, 128'h0F0F_0007, 0, 1'b0, -1, 7'd0, 2'b01);
    req_awvalid = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
